// File: rtl/tcdm_sram_responder.sv
// rtl/tcdm_sram_responder.sv - TCDM slave responder over a byte-masked word array; optional TCDM_RESP_STALL_EN grant stall
module tcdm_sram_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1C00_0000,
  parameter int                    LATENCY    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   add_i,
  input  logic                    wen_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    r_opc_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFFS  = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5);

  logic                  stall;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] rel_addr;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] in_rdata;
  logic                  in_opc;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [LATENCY-1:0]    pipe_valid;
  logic [LATENCY-1:0]    pipe_opc;
  logic [DATA_WIDTH-1:0] pipe_rdata [LATENCY];

`ifdef TCDM_RESP_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR (taps 8,6,5,4) that randomly withholds grants
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign gnt_o  = req_i & ~rst_i & ~stall;
  assign accept = req_i & gnt_o;

  // Word index relative to the bank base; the subtraction wraps so addresses below base land out of range
  assign rel_addr  = add_i - BASE_ADDR;
  assign word_addr = rel_addr >> OFFS;
  assign in_range  = (word_addr < ADDR_WIDTH'(MEM_WORDS));
  assign idx       = word_addr[IDX_W-1:0];

  // Response payload for the request presented this cycle
  always_comb begin
    in_rdata = '0;
    in_opc   = 1'b0;
    if (!in_range) begin
      in_opc = 1'b1;
      if (wen_i) begin
        in_rdata = ERR_DATA;
      end
    end else if (wen_i) begin
      in_rdata = mem[idx];
    end
  end

  // Byte-lane write into the array; out-of-range writes never touch it
  always_ff @(posedge clk_i) begin
    if (accept && !wen_i && in_range) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be_i[k]) begin
          mem[idx][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
    end
  end

  // Fixed-latency response shift register; payload is zeroed in bubbles so idle outputs read 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      pipe_opc   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_rdata[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_opc[0]   <= accept & in_opc;
      pipe_rdata[0] <= accept ? in_rdata : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_opc[i]   <= pipe_opc[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  assign r_valid_o = pipe_valid[LATENCY-1];
  assign r_opc_o   = pipe_opc[LATENCY-1];
  assign r_rdata_o = pipe_rdata[LATENCY-1];

endmodule

// File: tb/tb_tcdm_sram_responder.sv
// tb/tb_tcdm_sram_responder.sv - scoreboard bench driving LATENCY 1/3/4 responders with shared stimulus
module tb_tcdm_sram_responder;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        opc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        gnt   [3];
  logic        rv    [3];
  logic [31:0] rdata [3];
  logic        opc   [3];

  int    lat [3] = '{1, 3, 4};
  resp_t sbq [3][$];
  int    edge_cnt = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

`ifdef TCDM_RESP_STALL_EN
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end
  wire m_stall = (m_lfsr[1:0] == 2'b00);
`else
  wire m_stall = 1'b0;
`endif

  tcdm_sram_responder #(.LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[0]), .r_valid_o(rv[0]),
    .r_rdata_o(rdata[0]), .r_opc_o(opc[0])
  );

  tcdm_sram_responder #(.LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[1]), .r_valid_o(rv[1]),
    .r_rdata_o(rdata[1]), .r_opc_o(opc[1])
  );

  tcdm_sram_responder #(.LATENCY(4)) u_lat4 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt[2]), .r_valid_o(rv[2]),
    .r_rdata_o(rdata[2]), .r_opc_o(opc[2])
  );

  // Monitor: pops the scoreboard whenever a response appears and flags missing or stray ones
  always @(negedge clk) begin : monitor
    resp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rv[i] === 1'b1) begin
        n_checks++;
        if (sbq[i].size() == 0) begin
          n_fail++;
          $display("FAIL stray_rvalid lat%0d edge=%0d got data=%h opc=%b, want no response",
                   lat[i], edge_cnt, rdata[i], opc[i]);
        end else begin
          e = sbq[i].pop_front();
          if (e.due != edge_cnt || rdata[i] !== e.data || opc[i] !== e.opc) begin
            n_fail++;
            $display("FAIL resp lat%0d got edge=%0d data=%h opc=%b, want edge=%0d data=%h opc=%b",
                     lat[i], edge_cnt, rdata[i], opc[i], e.due, e.data, e.opc);
          end
        end
      end else begin
        n_checks++;
        if (rv[i] !== 1'b0 || rdata[i] !== 32'h0 || opc[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_outputs lat%0d edge=%0d got rv=%b data=%h opc=%b, want 0/0/0",
                   lat[i], edge_cnt, rv[i], rdata[i], opc[i]);
        end
        if (sbq[i].size() > 0 && sbq[i][0].due <= edge_cnt) begin
          e = sbq[i].pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_resp lat%0d edge=%0d got no r_valid, want data=%h opc=%b at edge %0d",
                   lat[i], edge_cnt, e.data, e.opc, e.due);
        end
      end
    end
  end

  // Present one request, hold it until granted, and queue the expected response per instance
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_d, input logic exp_o);
    int   tries;
    logic got;
    logic exp_g;
    req = 1'b1; wen = w; add = a; wdata = d; be = b;
    tries = 0;
    got   = 1'b0;
    while (!got && tries < 20) begin
      @(negedge clk);
      exp_g = req & ~rst & ~m_stall;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (gnt[i] !== exp_g) begin
          n_fail++;
          $display("FAIL gnt lat%0d addr=%h edge=%0d got %b, want %b", lat[i], a, edge_cnt, gnt[i], exp_g);
        end
      end
      if (exp_g) begin
        got = 1'b1;
        for (int i = 0; i < 3; i++) begin
          sbq[i].push_back('{due: edge_cnt + lat[i], data: exp_d, opc: exp_o});
        end
      end
      @(posedge clk); #1;
      tries++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout addr=%h got no gnt in 20 cycles, want gnt", a);
    end
  endtask

  task automatic idle();
    req = 1'b0; wen = 1'b1; add = 32'h0; wdata = 32'h0; be = 4'h0;
    @(posedge clk); #1;
  endtask

  // One-cycle reset pulse; anything still in flight is dropped from the expectations
  task automatic pulse_reset();
    int r;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    r = edge_cnt;
    for (int i = 0; i < 3; i++) begin
      while (sbq[i].size() > 0 && sbq[i][sbq[i].size()-1].due >= r) begin
        void'(sbq[i].pop_back());
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rv[i] !== 1'b0 || rdata[i] !== 32'h0 || opc[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset lat%0d got rv=%b data=%h opc=%b, want 0/0/0", lat[i], rv[i], rdata[i], opc[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wen = 1'b1; add = 32'h0; wdata = 32'h0; be = 4'h0;
    repeat (3) @(posedge clk);
    req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (gnt[i] !== 1'b0 || rv[i] !== 1'b0 || rdata[i] !== 32'h0 || opc[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state lat%0d got gnt=%b rv=%b data=%h opc=%b, want all 0",
                 lat[i], gnt[i], rv[i], rdata[i], opc[i]);
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b0;

    // T1 full-word write then read
    issue(1'b0, 32'h1C00_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0);
    issue(1'b1, 32'h1C00_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h1C00_0000, 32'h0000_00A0, 4'hF, 32'h0,         1'b0);
    // T2 byte mask, low address bits ignored, be=0 no-op
    issue(1'b0, 32'h1C00_0010, 32'h1122_3344, 4'b0101, 32'h0,      1'b0);
    issue(1'b1, 32'h1C00_0013, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0);
    issue(1'b0, 32'h1C00_0010, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0);
    issue(1'b1, 32'h1C00_0010, 32'h0,         4'h0, 32'hDE22_BE44, 1'b0);
    // T3 out of range (one past the end, below base via wrap, zero) and the last word
    issue(1'b1, 32'h1C00_1000, 32'h0,         4'h0, 32'hBADA_CCE5, 1'b1);
    issue(1'b0, 32'h1C00_1000, 32'h1234_5678, 4'hF, 32'h0,         1'b1);
    issue(1'b1, 32'h1C00_0000, 32'h0,         4'h0, 32'h0000_00A0, 1'b0);
    issue(1'b1, 32'h1BFF_FFFC, 32'h0,         4'h0, 32'hBADA_CCE5, 1'b1);
    issue(1'b1, 32'h0000_0000, 32'h0,         4'h0, 32'hBADA_CCE5, 1'b1);
    issue(1'b0, 32'h1C00_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0);
    issue(1'b1, 32'h1C00_0FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0);
    idle();
    // T4 back-to-back writes then back-to-back reads
    for (int i = 0; i < 8; i++) issue(1'b0, 32'h1C00_0100 + 32'(4*i), 32'hA500_0000 | 32'(i), 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) issue(1'b1, 32'h1C00_0100 + 32'(4*i), 32'h0, 4'h0, 32'hA500_0000 | 32'(i), 1'b0);
    idle();
    repeat (5) idle();
    // T5 reset two cycles after a read grant; memory survives reset
    issue(1'b1, 32'h1C00_0010, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
    idle();
    pulse_reset();
    repeat (6) idle();
    issue(1'b1, 32'h1C00_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
`ifdef TCDM_RESP_STALL_EN
    // T6 continuous requests against the reference grant pattern
    for (int i = 0; i < 64; i++) issue(1'b1, 32'h1C00_0000, 32'h0, 4'h0, 32'h0000_00A0, 1'b0);
`endif
    idle();
    repeat (8) idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (sbq[i].size() != 0) begin
        n_fail++;
        $display("FAIL drain lat%0d got %0d responses outstanding, want 0", lat[i], sbq[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
